alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
Reservation station plus two-stage issue pipe that feeds the combinational ALU in the out-of-order LC-3b core. It accepts renamed ALU ops from dispatch and snoops the CDB for missing operands. It sends the lowest-index ready entry to the ALU, registers the ALU result, and presents it with valid/ready to the CDB arbiter. It is the producer/consumer on the other side of the ALU's aluop/a/b -> f interface.

Parameters:
RS_DEPTH, 4, number of station entries (2..8)
TAG_W, 3, ROB tag width

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  synchronous squash (branch mispredict)
issue_valid  in  1  dispatch presents an op
issue_ready  out  1  at least one entry is free
issue_aluop  in  lc3b_aluop  operation
issue_dest  in  TAG_W  destination ROB tag
issue_vj, issue_vk  in  16 each  operand values
issue_qj, issue_qk  in  TAG_W each  producer tags
issue_rj, issue_rk  in  1 each  1 = operand value already valid
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  16  broadcast value
alu_aluop  out  lc3b_aluop  to ALU
alu_a, alu_b  out  16 each  to ALU
alu_f  in  16  ALU result (combinational from alu_*)
res_valid  out  1  result held
res_ready  in  1  CDB arbiter accepts
res_tag  out  TAG_W  result ROB tag
res_value  out  16  result

Behaviour:
- Reset is asynchronous and active-high. It clears every entry busy bit, ex_valid and res_valid. alu_aluop, alu_a, alu_b, res_tag and res_value reset to 0. issue_ready = 1 out of reset.
- Entry fields: busy, aluop, dest, vj/qj/rj, vk/qk/rk.
- issue_ready = OR of ~busy over all entries, from registered state only. It does not count an entry freed in the same cycle.
- Allocate: issue_valid && issue_ready writes the lowest-index free entry.
- CDB bypass on allocate: if issue_rj=0 and cdb_valid and cdb_tag==issue_qj, store vj=cdb_data, rj=1. Same rule for k.
- Snoop: every busy entry with rX=0 and qX==cdb_tag under cdb_valid captures vX and sets rX. Both operands may match one broadcast.
- Ready = busy && rj && rk, from registered bits. A CDB capture makes the entry eligible on the next cycle.
- Select: lowest-index ready entry.
- Pipe advances when adv = ~res_valid || res_ready.
- Execute stage: ex register holds aluop, a, b, tag and ex_valid, and drives alu_aluop/alu_a/alu_b.
  - When adv and a ready entry exists: load ex from that entry, set ex_valid, clear the entry's busy bit.
  - When adv and no ready entry exists: ex_valid <= 0. alu_* data holds its last value.
- Result stage: when adv, res_valid <= ex_valid, res_value <= alu_f, res_tag <= ex tag.
- Stall: when res_valid && ~res_ready, ex and res hold and no entry is selected. Allocation and snooping continue.
- Latency: op issued with both operands ready at edge t -> ex at t+1 -> res_valid at t+2. Throughput is 1 op/cycle with res_ready held high.
- Full: issue_ready=0 and issue_valid is ignored. No entry is overwritten.
- Flush: at the next edge, clears all busy bits, ex_valid and res_valid. Flush has priority over allocate, select and snoop.
- Reset mid-operation: all in-flight ops are discarded immediately, without waiting for a clock edge.
- ALU semantics (add/sub wrap mod 2^16, shifts use b[3:0]) belong to the ALU. This block passes operands unchanged: a=vj, b=vk.

Test Plan:
- Ready issue: add, vj=0x0003, vk=0x0004, rj=rk=1, dest=5, res_ready=1 -> two cycles later res_valid=1, res_tag=5, res_value=0x0007; issue_ready stays 1.
- CDB wakeup: and, rj=0 qj=2, vk=0x00FF; next cycle cdb tag 2 data 0x1234 -> no dispatch that cycle; result 0x0034 two cycles after capture.
- Same-cycle bypass and double match: issue with qj=qk=4, rj=rk=0, while cdb_valid tag 4 data 0x8000 -> both operands captured; sub gives 0x0000.
- Full/backpressure: RS_DEPTH ops not ready, res_ready=0 -> issue_ready=0 and the extra issue is dropped. Wake all with res_ready=0 -> res_valid holds tag/value stable. Raise res_ready -> results stream one per cycle, lowest index first.
- Flush: entries busy, ex_valid=1, res_valid=1, flush=1 -> next cycle res_valid=0, issue_ready=1; a later CDB broadcast of the old tags produces no result.
- Async reset mid-stream: assert reset between edges -> res_valid=0 and alu_*=0 immediately; after release, the first new op completes with normal latency.

Source files
------------

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rs
//  Purpose  : ALU reservation station with a two-stage issue pipe (execute
//             register feeding the combinational ALU, result register toward
//             the CDB arbiter). Snoops the CDB for missing operands.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_rs #(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  // dispatch side (aluop uses the 4-bit lc3b_aluop encoding)
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_aluop,
  input  logic [TAG_W-1:0] issue_dest,
  input  logic [15:0]      issue_vj,
  input  logic [15:0]      issue_vk,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic             issue_rj,
  input  logic             issue_rk,
  // common data bus snoop
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      cdb_data,
  // ALU interface
  output logic [3:0]       alu_aluop,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  input  logic [15:0]      alu_f,
  // result toward CDB arbiter
  output logic             res_valid,
  input  logic             res_ready,
  output logic [TAG_W-1:0] res_tag,
  output logic [15:0]      res_value
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  // Station entries
  logic [RS_DEPTH-1:0] busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
  logic [3:0]          aluop_q [RS_DEPTH];
  logic [3:0]          aluop_d [RS_DEPTH];
  logic [TAG_W-1:0]    dest_q  [RS_DEPTH];
  logic [TAG_W-1:0]    dest_d  [RS_DEPTH];
  logic [TAG_W-1:0]    qj_q    [RS_DEPTH];
  logic [TAG_W-1:0]    qj_d    [RS_DEPTH];
  logic [TAG_W-1:0]    qk_q    [RS_DEPTH];
  logic [TAG_W-1:0]    qk_d    [RS_DEPTH];
  logic [15:0]         vj_q    [RS_DEPTH];
  logic [15:0]         vj_d    [RS_DEPTH];
  logic [15:0]         vk_q    [RS_DEPTH];
  logic [15:0]         vk_d    [RS_DEPTH];

  // Execute and result stages
  logic             ex_valid_q, ex_valid_d;
  logic [3:0]       ex_aluop_q, ex_aluop_d;
  logic [15:0]      ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [TAG_W-1:0] ex_tag_q, ex_tag_d;
  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [15:0]      res_value_q, res_value_d;

  logic [RS_DEPTH-1:0] w_rdy;
  logic                w_adv;
  logic                w_sel_found, w_free_found;
  logic [IDX_W-1:0]    w_sel_idx, w_free_idx;

  // Readiness uses registered bits only, so a CDB capture is eligible next cycle
  assign w_rdy       = busy_q & rj_q & rk_q;
  assign w_adv       = ~res_valid_q | res_ready;
  assign issue_ready = w_free_found;

  assign alu_aluop = ex_aluop_q;
  assign alu_a     = ex_a_q;
  assign alu_b     = ex_b_q;
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;
  assign res_value = res_value_q;

  // Priority encoders: lowest-index ready entry and lowest-index free entry
  always_comb begin
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (w_rdy[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // Next state: flush wins; otherwise snoop, advance the pipe, then allocate
  always_comb begin
    busy_d = busy_q;  rj_d = rj_q;  rk_d = rk_q;
    aluop_d = aluop_q;  dest_d = dest_q;
    qj_d = qj_q;  qk_d = qk_q;  vj_d = vj_q;  vk_d = vk_q;
    ex_valid_d  = ex_valid_q;
    ex_aluop_d  = ex_aluop_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_tag_d    = ex_tag_q;
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_value_d = res_value_q;

    if (flush) begin
      busy_d      = '0;
      ex_valid_d  = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i] && cdb_valid) begin
          if (!rj_q[i] && qj_q[i] == cdb_tag) begin
            vj_d[i] = cdb_data;
            rj_d[i] = 1'b1;
          end
          if (!rk_q[i] && qk_q[i] == cdb_tag) begin
            vk_d[i] = cdb_data;
            rk_d[i] = 1'b1;
          end
        end
      end

      if (w_adv) begin
        res_valid_d = ex_valid_q;
        res_tag_d   = ex_tag_q;
        res_value_d = alu_f;
        ex_valid_d  = w_sel_found;
        if (w_sel_found) begin
          ex_aluop_d         = aluop_q[w_sel_idx];
          ex_a_d             = vj_q[w_sel_idx];
          ex_b_d             = vk_q[w_sel_idx];
          ex_tag_d           = dest_q[w_sel_idx];
          busy_d[w_sel_idx]  = 1'b0;
        end
      end

      // The chosen free entry is never busy, so it cannot collide with snoop/select
      if (issue_valid && w_free_found) begin
        busy_d[w_free_idx]  = 1'b1;
        aluop_d[w_free_idx] = issue_aluop;
        dest_d[w_free_idx]  = issue_dest;
        qj_d[w_free_idx]    = issue_qj;
        qk_d[w_free_idx]    = issue_qk;
        vj_d[w_free_idx]    = issue_vj;
        vk_d[w_free_idx]    = issue_vk;
        rj_d[w_free_idx]    = issue_rj;
        rk_d[w_free_idx]    = issue_rk;
        if (!issue_rj && cdb_valid && cdb_tag == issue_qj) begin
          vj_d[w_free_idx] = cdb_data;
          rj_d[w_free_idx] = 1'b1;
        end
        if (!issue_rk && cdb_valid && cdb_tag == issue_qk) begin
          vk_d[w_free_idx] = cdb_data;
          rk_d[w_free_idx] = 1'b1;
        end
      end
    end
  end

  // State registers; reset discards everything in flight immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      rj_q   <= '0;
      rk_q   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        aluop_q[i] <= '0;
        dest_q[i]  <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
      end
      ex_valid_q  <= 1'b0;
      ex_aluop_q  <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_tag_q    <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_value_q <= '0;
    end else begin
      busy_q      <= busy_d;
      rj_q        <= rj_d;
      rk_q        <= rk_d;
      aluop_q     <= aluop_d;
      dest_q      <= dest_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      ex_valid_q  <= ex_valid_d;
      ex_aluop_q  <= ex_aluop_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_tag_q    <= ex_tag_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_value_q <= res_value_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_rs
//  Purpose  : Self-checking bench for alu_rs with a behavioural station model,
//             a combinational LC-3b ALU and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rs;

  localparam int RS_DEPTH = 4;
  localparam int TAG_W    = 3;

  localparam logic [3:0] OP_ADD = 4'd0, OP_AND = 4'd1, OP_SUB = 4'd7;

  logic             clk, reset, flush;
  logic             issue_valid, issue_ready;
  logic [3:0]       issue_aluop;
  logic [TAG_W-1:0] issue_dest, issue_qj, issue_qk;
  logic [15:0]      issue_vj, issue_vk;
  logic             issue_rj, issue_rk;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [15:0]      cdb_data;
  logic [3:0]       alu_aluop;
  logic [15:0]      alu_a, alu_b, alu_f;
  logic             res_valid, res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [15:0]      res_value;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  alu_rs #(.RS_DEPTH(RS_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_aluop(issue_aluop), .issue_dest(issue_dest),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_rj(issue_rj), .issue_rk(issue_rk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_value(res_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LC-3b ALU behaviour (add/sub wrap, shifts by b[3:0])
  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a & b;
      4'd2:    return ~a;
      4'd3:    return a;
      4'd4:    return a << b[3:0];
      4'd5:    return a >> b[3:0];
      4'd6:    return 16'($signed(a) >>> b[3:0]);
      4'd7:    return a - b;
      default: return a;
    endcase
  endfunction

  assign alu_f = alu_ref(alu_aluop, alu_a, alu_b);

  // ---------------- behavioural model ----------------
  typedef struct {
    bit              busy;
    bit [3:0]        op;
    bit [TAG_W-1:0]  dest, qj, qk;
    bit [15:0]       vj, vk;
    bit              rj, rk;
  } ent_t;

  ent_t            m_ent [RS_DEPTH];
  bit              m_ex_v, m_res_v;
  bit [3:0]        m_ex_op;
  bit [15:0]       m_ex_a, m_ex_b, m_res_val;
  bit [TAG_W-1:0]  m_ex_tag, m_res_tag;

  task automatic model_reset();
    for (int i = 0; i < RS_DEPTH; i++) m_ent[i] = '{default: 0};
    m_ex_v = 0; m_ex_op = 0; m_ex_a = 0; m_ex_b = 0; m_ex_tag = 0;
    m_res_v = 0; m_res_val = 0; m_res_tag = 0;
  endtask

  // One clock edge worth of behaviour, from the inputs held at the edge
  task automatic model_step();
    ent_t old [RS_DEPTH];
    bit adv, sel_f, fr_f;
    int sel, fr;
    old   = m_ent;
    adv   = !m_res_v || res_ready;
    sel_f = 0; fr_f = 0; sel = 0; fr = 0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!sel_f && old[i].busy && old[i].rj && old[i].rk) begin sel_f = 1; sel = i; end
      if (!fr_f && !old[i].busy) begin fr_f = 1; fr = i; end
    end
    if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) m_ent[i].busy = 0;
      m_ex_v = 0; m_res_v = 0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++)
        if (old[i].busy && cdb_valid) begin
          if (!old[i].rj && old[i].qj == cdb_tag) begin m_ent[i].vj = cdb_data; m_ent[i].rj = 1; end
          if (!old[i].rk && old[i].qk == cdb_tag) begin m_ent[i].vk = cdb_data; m_ent[i].rk = 1; end
        end
      if (adv) begin
        m_res_v   = m_ex_v;
        m_res_tag = m_ex_tag;
        m_res_val = alu_ref(m_ex_op, m_ex_a, m_ex_b);
        m_ex_v    = sel_f;
        if (sel_f) begin
          m_ex_op = old[sel].op; m_ex_a = old[sel].vj; m_ex_b = old[sel].vk;
          m_ex_tag = old[sel].dest;
          m_ent[sel].busy = 0;
        end
      end
      if (issue_valid && fr_f) begin
        m_ent[fr].busy = 1; m_ent[fr].op = issue_aluop; m_ent[fr].dest = issue_dest;
        m_ent[fr].qj = issue_qj; m_ent[fr].qk = issue_qk;
        m_ent[fr].vj = issue_vj; m_ent[fr].vk = issue_vk;
        m_ent[fr].rj = issue_rj; m_ent[fr].rk = issue_rk;
        if (!issue_rj && cdb_valid && cdb_tag == issue_qj) begin m_ent[fr].vj = cdb_data; m_ent[fr].rj = 1; end
        if (!issue_rk && cdb_valid && cdb_tag == issue_qk) begin m_ent[fr].vk = cdb_data; m_ent[fr].rk = 1; end
      end
    end
  endtask

  function automatic bit model_issue_ready();
    for (int i = 0; i < RS_DEPTH; i++) if (!m_ent[i].busy) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: compare DUT outputs with the model on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_issue_ready", {31'd0, issue_ready}, {31'd0, model_issue_ready()});
      chk("m_res_valid",   {31'd0, res_valid},   {31'd0, m_res_v});
      if (m_res_v) begin
        chk("m_res_tag",   {29'd0, res_tag},   {29'd0, m_res_tag});
        chk("m_res_value", {16'd0, res_value}, {16'd0, m_res_val});
      end
      chk("m_alu_aluop", {28'd0, alu_aluop}, {28'd0, m_ex_op});
      chk("m_alu_a",     {16'd0, alu_a},     {16'd0, m_ex_a});
      chk("m_alu_b",     {16'd0, alu_b},     {16'd0, m_ex_b});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [TAG_W-1:0] dest,
                       input logic [15:0] vj, input logic [15:0] vk,
                       input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk,
                       input logic rj, input logic rk);
    issue_valid = 1; issue_aluop = op; issue_dest = dest;
    issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
    issue_rj = rj; issue_rk = rk;
  endtask

  task automatic cdb(input logic v, input logic [TAG_W-1:0] t, input logic [15:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; flush = 0; res_ready = 0;
    issue_valid = 0; issue_aluop = 0; issue_dest = 0; issue_vj = 0; issue_vk = 0;
    issue_qj = 0; issue_qk = 0; issue_rj = 0; issue_rk = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    model_reset();
    #1 reset = 1;
    model_reset();
    #1;
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_res_valid",   {31'd0, res_valid},   32'd0);
    chk("rst_alu_a",       {16'd0, alu_a},       32'd0);
    chk("rst_res_value",   {16'd0, res_value},   32'd0);
    #6 reset = 0;
    cmp_en = 1;

    // Ready issue: 3 + 4 -> tag 5 after two edges
    res_ready = 1;
    issue(OP_ADD, 3'd5, 16'h0003, 16'h0004, 3'd0, 3'd0, 1, 1);
    cyc();
    issue_valid = 0;
    cyc();
    chk("t1_alu_a", {16'd0, alu_a}, 32'h3);
    cyc();
    chk("t1_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t1_res_tag",   {29'd0, res_tag},   32'd5);
    chk("t1_res_value", {16'd0, res_value}, 32'h0007);
    chk("t1_issue_ready", {31'd0, issue_ready}, 32'd1);

    // CDB wakeup: and with vj pending on tag 2
    issue(OP_AND, 3'd3, 16'hDEAD, 16'h00FF, 3'd2, 3'd0, 0, 1);
    cyc();
    issue_valid = 0;
    cdb(1, 3'd2, 16'h1234);
    cyc();
    cdb(0, 3'd0, 16'h0000);
    chk("t2_no_dispatch", {16'd0, alu_a}, 32'h3);
    cyc();
    chk("t2_alu_a", {16'd0, alu_a}, 32'h1234);
    cyc();
    chk("t2_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t2_res_tag",   {29'd0, res_tag},   32'd3);
    chk("t2_res_value", {16'd0, res_value}, 32'h0034);

    // Same-cycle bypass of both operands from one broadcast
    issue(OP_SUB, 3'd6, 16'h1111, 16'h2222, 3'd4, 3'd4, 0, 0);
    cdb(1, 3'd4, 16'h8000);
    cyc();
    issue_valid = 0;
    cdb(0, 3'd0, 16'h0000);
    cyc();
    chk("t3_alu_a", {16'd0, alu_a}, 32'h8000);
    chk("t3_alu_b", {16'd0, alu_b}, 32'h8000);
    cyc();
    chk("t3_res_tag",   {29'd0, res_tag},   32'd6);
    chk("t3_res_value", {16'd0, res_value}, 32'h0000);
    cyc();
    chk("t3_drained", {31'd0, res_valid}, 32'd0);

    // Full and backpressure: four ops waiting on tag 7
    res_ready = 0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      issue(OP_ADD, TAG_W'(i), 16'h0000, 16'(i), 3'd7, 3'd0, 0, 1);
      cyc();
    end
    chk("t4_full", {31'd0, issue_ready}, 32'd0);
    issue(OP_ADD, 3'd7, 16'hAAAA, 16'h0001, 3'd0, 3'd0, 1, 1);
    cyc();
    issue_valid = 0;
    cdb(1, 3'd7, 16'h0100);
    cyc();
    cdb(0, 3'd0, 16'h0000);
    cyc();
    cyc();
    chk("t4_hold_valid", {31'd0, res_valid}, 32'd1);
    chk("t4_hold_tag",   {29'd0, res_tag},   32'd0);
    chk("t4_hold_value", {16'd0, res_value}, 32'h0100);
    cyc();
    cyc();
    chk("t4_stall_tag",   {29'd0, res_tag},   32'd0);
    chk("t4_stall_value", {16'd0, res_value}, 32'h0100);
    res_ready = 1;
    for (int i = 1; i < RS_DEPTH; i++) begin
      cyc();
      chk("t4_stream_tag",   {29'd0, res_tag},   32'(i));
      chk("t4_stream_value", {16'd0, res_value}, 32'h0100 + 32'(i));
    end
    cyc();
    chk("t4_dropped", {31'd0, res_valid}, 32'd0);

    // Flush with busy entries, ex_valid and res_valid all set
    res_ready = 0;
    issue(OP_ADD, 3'd1, 16'h0001, 16'h0001, 3'd0, 3'd0, 1, 1); cyc();
    issue(OP_ADD, 3'd2, 16'h0002, 16'h0001, 3'd0, 3'd0, 1, 1); cyc();
    issue(OP_ADD, 3'd3, 16'h0000, 16'h0001, 3'd5, 3'd0, 0, 1); cyc();
    issue(OP_ADD, 3'd4, 16'h0000, 16'h0001, 3'd5, 3'd0, 0, 1); cyc();
    issue_valid = 0;
    chk("t5_pre_res_valid", {31'd0, res_valid}, 32'd1);
    flush = 1;
    cyc();
    flush = 0;
    chk("t5_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t5_issue_ready", {31'd0, issue_ready}, 32'd1);
    res_ready = 1;
    cdb(1, 3'd5, 16'h0009);
    cyc();
    cdb(0, 3'd0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_no_result", {31'd0, res_valid}, 32'd0);
    end

    // Asynchronous reset between edges
    issue(OP_ADD, 3'd1, 16'h0002, 16'h0002, 3'd0, 3'd0, 1, 1); cyc();
    issue_valid = 0;
    cyc();
    cyc();
    chk("t6_pre_res_valid", {31'd0, res_valid}, 32'd1);
    #2 reset = 1;
    model_reset();
    #1;
    chk("t6_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t6_alu_a",     {16'd0, alu_a},     32'd0);
    chk("t6_alu_b",     {16'd0, alu_b},     32'd0);
    chk("t6_issue_ready", {31'd0, issue_ready}, 32'd1);
    #2 reset = 0;
    issue(OP_ADD, 3'd4, 16'h0005, 16'h0006, 3'd0, 3'd0, 1, 1);
    cyc();
    issue_valid = 0;
    cyc();
    cyc();
    chk("t6_res_valid_after", {31'd0, res_valid}, 32'd1);
    chk("t6_res_tag",   {29'd0, res_tag},   32'd4);
    chk("t6_res_value", {16'd0, res_value}, 32'h000B);

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
